// File: rtl/pointwise_scheduler.sv
// Pointwise PE sequencer: walks output channels x input groups, accumulates PE partial sums, and queues results.
// Optional build macro POINTWISE_SCHED_RELU_EN clamps negative results to zero on their way into the FIFO.
module pointwise_scheduler #(
  parameter int DATA_WIDTH     = 16,
  parameter int PE_LATENCY     = 3,
  parameter int RD_LATENCY     = 1,
  parameter int OUT_FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              cfg_in_groups,
  input  logic [7:0]              cfg_out_channels,
  output logic                    busy,
  output logic                    done,
  output logic                    buf_rd_en,
  output logic [7:0]              buf_group,
  output logic [7:0]              buf_och,
  output logic [7:0]              pe_input_channel_sel,
  output logic [7:0]              pe_output_channel_sel,
  input  logic [2*DATA_WIDTH-1:0] pe_result,
  input  logic [7:0]              pe_output_channel_sel_d,
  output logic                    out_valid,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic [7:0]              out_channel,
  input  logic                    out_ready
);

  localparam int RES_W = 2 * DATA_WIDTH;
  localparam int TRK   = RD_LATENCY + PE_LATENCY;
  localparam int PTR_W = $clog2(OUT_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUT_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state;
  logic [7:0]              g_cfg, c_cfg, grp, och;
  logic [CNT_W-1:0]        reserved, fifo_cnt;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic signed [RES_W-1:0] fifo_data [OUT_FIFO_DEPTH];
  logic [7:0]              fifo_ch   [OUT_FIFO_DEPTH];
  logic                    vld_p     [TRK];
  logic                    first_p   [TRK];
  logic                    last_p    [TRK];
  logic [7:0]              och_p     [TRK];
  logic [7:0]              grp_dly   [RD_LATENCY];
  logic [7:0]              och_dly   [RD_LATENCY];
  logic signed [RES_W-1:0] acc, acc_next;
  logic                    issue, issue_first, arr_vld, push, pop, final_push;

  function automatic logic signed [RES_W-1:0] clamp_result(input logic signed [RES_W-1:0] v);
`ifdef POINTWISE_SCHED_RELU_EN
    return v[RES_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // A new output channel needs a FIFO slot reserved up front, so the PE never has to stall.
  assign issue       = (state == ISSUE) && ((grp != 8'd0) || (reserved < DEPTH_C));
  assign issue_first = issue && (grp == 8'd0);
  assign arr_vld     = vld_p[TRK-1];
  assign push        = arr_vld && last_p[TRK-1];
  assign final_push  = push && (och_p[TRK-1] == c_cfg - 8'd1);
  assign out_valid   = (fifo_cnt != '0);
  assign pop         = out_valid && out_ready;
  assign acc_next    = first_p[TRK-1] ? $signed(pe_result) : acc + $signed(pe_result);

  assign buf_rd_en             = issue;
  assign buf_group             = grp;
  assign buf_och               = och;
  assign pe_input_channel_sel  = grp_dly[RD_LATENCY-1];
  assign pe_output_channel_sel = och_dly[RD_LATENCY-1];
  assign out_data              = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_channel           = out_valid ? fifo_ch[rd_ptr] : 8'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      g_cfg <= 8'd0;
      c_cfg <= 8'd0;
      grp   <= 8'd0;
      och   <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            g_cfg <= cfg_in_groups;
            c_cfg <= cfg_out_channels;
            grp   <= 8'd0;
            och   <= 8'd0;
            busy  <= 1'b1;
            if ((cfg_in_groups == 8'd0) || (cfg_out_channels == 8'd0)) done <= 1'b1;
            else state <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            if (grp == g_cfg - 8'd1) begin
              grp <= 8'd0;
              if (och == c_cfg - 8'd1) state <= DRAIN;
              else och <= och + 8'd1;
            end else begin
              grp <= grp + 8'd1;
            end
          end
        end
        DRAIN: begin
          if (final_push) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage boundary: buffer read -> PE select inputs, RD_LATENCY cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        grp_dly[i] <= 8'd0;
        och_dly[i] <= 8'd0;
      end
    end else begin
      grp_dly[0] <= grp;
      och_dly[0] <= och;
      for (int i = 1; i < RD_LATENCY; i++) begin
        grp_dly[i] <= grp_dly[i-1];
        och_dly[i] <= och_dly[i-1];
      end
    end
  end

  // Stage boundary: read issue -> PE result arrival, tracked over RD_LATENCY+PE_LATENCY cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TRK; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < TRK; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    first_p[0] <= (grp == 8'd0);
    last_p[0]  <= (grp == g_cfg - 8'd1);
    och_p[0]   <= och;
    for (int i = 1; i < TRK; i++) begin
      first_p[i] <= first_p[i-1];
      last_p[i]  <= last_p[i-1];
      och_p[i]   <= och_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else if (arr_vld) acc <= acc_next;
  end

  // Stage boundary: accumulated result -> output FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      reserved <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      case ({issue_first, pop})
        2'b10:   reserved <= reserved + CNT_W'(1);
        2'b01:   reserved <= reserved - CNT_W'(1);
        default: reserved <= reserved;
      endcase
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= clamp_result(acc_next);
      fifo_ch[wr_ptr]   <= pe_output_channel_sel_d;
    end
  end

endmodule

// File: doc/pointwise_scheduler.md
# pointwise_scheduler

Sequencing controller for the pointwise PE (`compute_engine_p`). It walks output channels and 8-wide input-channel groups and drives buffer read addresses. It feeds the PE's channel-select inputs in step with buffer data, and accumulates the PE's per-group partial sums into one result per output channel. Completed results go out through an internal FIFO with a valid/ready handshake. It sits between the feature/weight buffers plus the PE, and the write-back/quantization stage.

## Interface
Parameters:
- `DATA_WIDTH`, 16: PE operand width; result/accumulator width is 2*DATA_WIDTH.
- `PE_LATENCY`, 3: cycles from buffer data presented at the PE to PE `result` plus delayed selects valid.
- `RD_LATENCY`, 1: buffer read latency, from `buf_rd_en` to data at the PE inputs.
- `OUT_FIFO_DEPTH`, 8: result FIFO entries; power of two, ≥ PE_LATENCY+RD_LATENCY+2.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request to begin a layer; ignored while `busy`.
- `cfg_in_groups`  in  8: number of 8-channel input groups G.
- `cfg_out_channels`  in  8: number of output channels C.
- `busy`  out  1: layer in progress. Reset 0.
- `done`  out  1: one-cycle pulse when the last result enters the FIFO. Reset 0.
- `buf_rd_en`  out  1: buffer read strobe. Reset 0.
- `buf_group`  out  8: input-group address. Reset 0.
- `buf_och`  out  8: output-channel address, for the weight buffer. Reset 0.
- `pe_input_channel_sel`  out  8: to PE `input_channel_sel`; `buf_group` delayed RD_LATENCY cycles. Reset 0.
- `pe_output_channel_sel`  out  8: to PE `output_channel_sel`; `buf_och` delayed RD_LATENCY cycles. Reset 0.
- `pe_result`  in  2*DATA_WIDTH: PE `result`.
- `pe_output_channel_sel_d`  in  8: PE `output_channel_sel_delay3`.
- `out_valid`  out  1: FIFO non-empty. Reset 0.
- `out_data`  out  2*DATA_WIDTH: head result. Reset 0.
- `out_channel`  out  8: head result's output channel. Reset 0.
- `out_ready`  in  1: consumer accepts the head when `out_valid && out_ready`.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - On `start`, latch G and C, clear counters, and assert `busy`.
  - If G==0 or C==0, pulse `done` next cycle and stay IDLE, with no reads.
  - Otherwise go to ISSUE.
- ISSUE: loop order is output channel outer (0..C-1), group inner (0..G-1). One read is issued per cycle when permitted.
- Credit rule:
  - Issuing group 0 of a channel requires `reserved < OUT_FIFO_DEPTH`.
  - `reserved` is FIFO occupancy plus channels issued but not yet pushed.
  - Issuing group 0 increments `reserved`; a FIFO pop decrements it. Both in one cycle leave it unchanged.
  - Without a credit, `buf_rd_en`=0 and the counters hold. This is the only stall; the PE is never stalled.
- After the final read (och C-1, group G-1), go to DRAIN.
- Tracking: a shift register of depth RD_LATENCY+PE_LATENCY carries {valid, first, last, och} per issued read.
- Arrival handling, when the tail is valid:
  - `first`: acc ← pe_result.
  - Otherwise: acc ← acc + pe_result.
  - `last`: push (acc_next, och) into the FIFO.
- If G==1, each arrival is both first and last.
- Arithmetic: two's-complement, 2*DATA_WIDTH bits, wrap on overflow (no saturation), matching the PE adder.
- DRAIN: when the last push occurs, pulse `done`, clear `busy`, and return to IDLE. The FIFO keeps draining independently.
- The next `start` is accepted the cycle after `done`.
- Reset:
  - Reset mid-operation clears the state, counters, tracking pipe, FIFO, accumulator and `reserved`.
  - In-flight PE results are discarded. No `done` is produced.

## Timing
- `start` sampled at edge 0 → first `buf_rd_en` high in cycle 1.
- Matching `pe_*_sel` in cycle 1+RD_LATENCY.
- PE result in cycle 1+RD_LATENCY+PE_LATENCY.
- With no credit stall: reads occupy cycles 1..G*C.
- The last result is pushed at the end of cycle G*C+RD_LATENCY+PE_LATENCY.
- `done` and that entry's `out_valid` are visible the next cycle, G*C+5 with defaults.
- FIFO: a push and a pop in the same cycle are both honoured.
  - A push to a full FIFO is impossible by the credit rule.
  - A pop from an empty FIFO is ignored.
- `out_data`/`out_channel` hold stable while `out_valid && !out_ready`.

## Configuration
- `POINTWISE_SCHED_RELU_EN`:
  - Defined: a value pushed into the FIFO that is negative (MSB set) is replaced with 0.
  - Undefined: the raw accumulated sum is pushed.
- The accumulator itself is never clamped.

## Test plan
- G=1, C=1, `pe_result`=100 (model PE), `out_ready`=1 → `out_data`=100, `out_channel`=0, `done` in cycle 6, one beat only.
- G=3, C=2, per-group results 10/20/-5 (och0) and 7/7/7 (och1) → beats (25, ch0) then (21, ch1); reads in cycles 1..6.
- G=1, C=20, `out_ready`=0 → exactly 8 reads issued, then `buf_rd_en`=0. Raising `out_ready` resumes issue; all 20 beats arrive in channel order 0..19.
- `cfg_out_channels`=0 → `done` in cycle 1, `buf_rd_en` never asserted, `out_valid` stays 0.
- `rst` asserted mid-ISSUE with results in flight → next cycle `busy`=0 and `out_valid`=0. A following start with G=1, C=1 yields a single correct beat.
- Overflow and clamp, with G=2, per-group results 0x7FFFFFFF and 1:
  - Without `POINTWISE_SCHED_RELU_EN` → 0x80000000.
  - With it → 0.
